stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Controller that sequences the 16-bit T-flip-flop counter and its four hex displays as a stopwatch. It turns three push-button levels into single-cycle commands and generates the counter's En and Clr from a prescaled tick. It also holds a lap snapshot for the display and stops the count at full scale instead of wrapping. It sits between the board keys/switches and the counter/hex_ssd datapath.

Parameters:
DIV, 4, prescaler ratio: one counter increment per DIV Clk cycles while running (DIV >= 2).
PW, 2, prescaler width; must satisfy 2**PW >= DIV.

Ports:
Clk  input  1  system clock; all state on rising edge
Resetn  input  1  asynchronous active-low reset
StartStop  input  1  button level, active-high; rising edge = start/pause command
Lap  input  1  button level, active-high; rising edge = lap freeze/release command
ClrBtn  input  1  button level, active-high; rising edge = clear command
Q  input  16  live counter value from the 16-bit counter
En  output  1  counter enable, one-cycle pulse per tick
Clr  output  1  counter synchronous clear, active-high
Disp  output  16  value routed to the four hex_ssd digits (Disp[3:0] to HEX0)
Running  output  1  high in RUN or LAP
Ovf  output  1  sticky full-scale flag

Behaviour:
- Reset (Resetn low, async): state=IDLE, prescaler=0, Hold=0, Ovf=0, edge-detect regs=0, Clr=1. Clr stays 1 through the first Clk edge after Resetn rises, then drops to 0. This zeroes the counter, which has no reset of its own.
- Edge detect: per button, prev<=level each cycle; cmd = level & ~prev, so cmd is 1 cycle wide. A held button issues exactly one command.
- Command priority when several fire in the same cycle: ClrBtn > StartStop > Lap. Lower-priority commands in that cycle are dropped.
- States: IDLE, RUN, PAUSE, LAP, HALT (3-bit encoded register).
  - IDLE: StartStop -> RUN, prescaler := 0.
  - RUN: StartStop -> PAUSE; Lap -> LAP, Hold := Q (value sampled that cycle).
  - PAUSE: StartStop -> RUN, prescaler keeps its value (no restart of partial period).
  - LAP: StartStop -> PAUSE (display returns to live); Lap -> RUN (release).
  - HALT: only ClrBtn exits.
  - Any state on ClrBtn: -> IDLE, Clr=1 for exactly one cycle (registered), prescaler := 0, Ovf := 0, Hold := 0.
- Prescaler: increments only in RUN or LAP; wraps DIV-1 -> 0. Tick = (prescaler==DIV-1) & (state RUN or LAP).
- En = Tick & (Q != 16'hFFFF), combinational from registers and Q.
- Full scale: if Tick and Q==16'hFFFF, then En=0, Ovf:=1, state:=HALT. The counter must never wrap to 0000. Ovf holds until ClrBtn or reset.
- Disp = Hold in LAP, else Q. Running = state in {RUN, LAP}.
- Counter keeps counting during LAP (En unaffected); only Disp is frozen.
- Latency: StartStop edge at cycle n -> state RUN at n+1 -> first En pulse at n+DIV (prescaler 0..DIV-1).
- Clr and En are never both 1 in a cycle; ClrBtn in the cycle of a Tick suppresses that En.
- Reset mid-operation: asynchronous return to reset values regardless of state; the counter is re-cleared by the post-reset Clr pulse.

Test Plan:
- Reset release, all buttons 0 -> Clr=1 for exactly one Clk after Resetn rises, then 0; state IDLE; En never pulses; Disp=Q=0000.
- DIV=4, StartStop pulse then hold 40 cycles -> En pulses every 4th cycle, first 4 cycles after the edge; Q=000A after 40 cycles; Running=1; holding the button high issues no second command.
- RUN at Q=0005, Lap edge -> Disp stays 0005 while Q advances to 0009; second Lap -> Disp tracks Q; StartStop in LAP -> PAUSE, Disp=Q, En stops.
- Force Q=FFFE (preload the counter model) in RUN -> En raises Q to FFFF; next Tick gives En=0, Ovf=1, HALT, Q stays FFFF; StartStop ignored; ClrBtn -> Clr pulse, Ovf=0, IDLE, Q=0000.
- StartStop, Lap and ClrBtn rising in the same cycle from RUN -> IDLE, one-cycle Clr, no En that cycle, Hold=0.
- Resetn low for 1 cycle mid-RUN, asynchronous to Clk -> outputs immediately at reset values; after release the Clr pulse zeroes Q and state is IDLE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer for the 16-bit counter and hex displays.
// Turns button edges into commands and drives the counter En/Clr.
module stopwatch_ctrl #(
    parameter int DIV = 4,
    parameter int PW  = 2
) (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        StartStop,
    input  logic        Lap,
    input  logic        ClrBtn,
    input  logic [15:0] Q,
    output logic        En,
    output logic        Clr,
    output logic [15:0] Disp,
    output logic        Running,
    output logic        Ovf
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [15:0]   hold_q;
    logic          ovf_q;
    logic          clr_q;
    logic          run_q;
    logic          lap_q;
    logic          ss_prev_q;
    logic          lap_prev_q;
    logic          clr_prev_q;

    logic cmd_ss;
    logic cmd_lap;
    logic cmd_clr;
    logic active;
    logic tick;
    logic full;

    assign cmd_ss  = StartStop & ~ss_prev_q;
    assign cmd_lap = Lap & ~lap_prev_q;
    assign cmd_clr = ClrBtn & ~clr_prev_q;

    assign active = (state_q == RUN) || (state_q == LAP);
    assign tick   = active && (presc_q == LAST);
    assign full   = (Q == 16'hFFFF);

    assign presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;

    // A clear command on a tick cycle wins over the increment.
    assign En      = tick & ~full & ~cmd_clr;
    assign Clr     = clr_q;
    assign Disp    = lap_q ? hold_q : Q;
    assign Running = run_q;
    assign Ovf     = ovf_q;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            hold_q     <= '0;
            ovf_q      <= 1'b0;
            clr_q      <= 1'b1;
            run_q      <= 1'b0;
            lap_q      <= 1'b0;
            ss_prev_q  <= 1'b0;
            lap_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            ss_prev_q  <= StartStop;
            lap_prev_q <= Lap;
            clr_prev_q <= ClrBtn;
            clr_q      <= 1'b0;
            if (active) begin
                presc_q <= presc_d;
            end
            if (cmd_clr) begin
                state_q <= IDLE;
                clr_q   <= 1'b1;
                presc_q <= '0;
                ovf_q   <= 1'b0;
                hold_q  <= '0;
                run_q   <= 1'b0;
                lap_q   <= 1'b0;
            end else if (tick && full) begin
                // Stop at full scale rather than wrap to zero.
                state_q <= HALT;
                ovf_q   <= 1'b1;
                run_q   <= 1'b0;
                lap_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cmd_ss) begin
                            state_q <= RUN;
                            presc_q <= '0;
                            run_q   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (cmd_ss) begin
                            state_q <= PAUSE;
                            run_q   <= 1'b0;
                        end else if (cmd_lap) begin
                            state_q <= LAP;
                            hold_q  <= Q;
                            lap_q   <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (cmd_ss) begin
                            state_q <= RUN;
                            run_q   <= 1'b1;
                        end
                    end
                    LAP: begin
                        if (cmd_ss) begin
                            state_q <= PAUSE;
                            run_q   <= 1'b0;
                            lap_q   <= 1'b0;
                        end else if (cmd_lap) begin
                            state_q <= RUN;
                            lap_q   <= 1'b0;
                        end
                    end
                    HALT: begin
                        state_q <= HALT;
                    end
                    default: begin
                        state_q <= IDLE;
                        run_q   <= 1'b0;
                        lap_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a behavioural model of the counter.
// Vector table for the run/pause/clear flow, sequences for corners.
module tb_stopwatch_ctrl;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        StartStop = 1'b0;
    logic        Lap = 1'b0;
    logic        ClrBtn = 1'b0;
    logic [15:0] Q;
    logic        En;
    logic        Clr;
    logic [15:0] Disp;
    logic        Running;
    logic        Ovf;

    logic        load_en = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] q_m;

    int tests = 0;
    int fails = 0;

    stopwatch_ctrl #(.DIV(4), .PW(2)) dut (
        .Clk(Clk),
        .Resetn(Resetn),
        .StartStop(StartStop),
        .Lap(Lap),
        .ClrBtn(ClrBtn),
        .Q(Q),
        .En(En),
        .Clr(Clr),
        .Disp(Disp),
        .Running(Running),
        .Ovf(Ovf)
    );

    always #5 Clk = ~Clk;

    assign Q = q_m;

    always @(posedge Clk) begin
        if (Clr) q_m <= 16'h0000;
        else if (load_en) q_m <= load_val;
        else if (En) q_m <= q_m + 16'd1;
    end

    typedef struct {
        logic        ss;
        logic        lp;
        logic        cb;
        logic        en;
        logic        clr;
        logic        run;
        logic        ovf;
        logic [15:0] disp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ss, lp, cb, en, clr, run, ovf,
                                input logic [15:0] disp);
        vec_t v;
        v.ss = ss; v.lp = lp; v.cb = cb;
        v.en = en; v.clr = clr; v.run = run; v.ovf = ovf;
        v.disp = disp;
        return v;
    endfunction

    task automatic chkb(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic l, input logic c);
        @(posedge Clk);
        #1;
        StartStop = s;
        Lap = l;
        ClrBtn = c;
        @(negedge Clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic bad;
        logic [15:0] hv;
        logic [15:0] qp;

        for (int i = 0; i <= 41; i++)
            tbl.push_back(mk(1, 0, 0, (i > 0) && (i % 4 == 0), 0, i > 0, 0,
                             (i == 0) ? 16'd0 : 16'((i - 1) / 4)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'd10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'd10));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 16'd10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 16'd11));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd11));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'd11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'd11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'd11));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 16'd11));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 16'd12));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 16'd12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd0));

        // reset and release
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chkb("rst.Clr", Clr, 1'b1);
        chkb("rst.En", En, 1'b0);
        chkb("rst.Running", Running, 1'b0);
        chkb("rst.Ovf", Ovf, 1'b0);
        chkw("rst.Disp", Disp, 16'h0000);
        @(posedge Clk);
        #2 Resetn = 1'b1;
        @(negedge Clk);
        chkb("rel.Clr_hold", Clr, 1'b1);
        cyc(0, 0, 0);
        chkb("rel.Clr_drop", Clr, 1'b0);
        chkb("rel.En", En, 1'b0);
        chkb("rel.Running", Running, 1'b0);
        chkw("rel.Disp", Disp, 16'h0000);

        foreach (tbl[i]) begin
            cyc(tbl[i].ss, tbl[i].lp, tbl[i].cb);
            chkb($sformatf("v%0d.En", i), En, tbl[i].en);
            chkb($sformatf("v%0d.Clr", i), Clr, tbl[i].clr);
            chkb($sformatf("v%0d.Running", i), Running, tbl[i].run);
            chkb($sformatf("v%0d.Ovf", i), Ovf, tbl[i].ovf);
            chkw($sformatf("v%0d.Disp", i), Disp, tbl[i].disp);
        end

        // lap freeze / release / pause from lap
        cyc(1, 0, 0);
        n = 0;
        while (Q != 16'd5 && n < 100) begin cyc(0, 0, 0); n++; end
        chkw("lap.reach5", Q, 16'd5);
        cyc(0, 1, 0);
        chkw("lap.cmd_disp", Disp, 16'd5);
        bad = 1'b0;
        n = 0;
        while (Q != 16'd9 && n < 100) begin
            cyc(0, 0, 0);
            n++;
            if (Disp !== 16'd5) bad = 1'b1;
        end
        chkb("lap.frozen", bad, 1'b0);
        chkw("lap.q9", Q, 16'd9);
        chkw("lap.disp5", Disp, 16'd5);
        chkb("lap.running", Running, 1'b1);
        cyc(0, 1, 0);
        chkw("lap.rel_cmd", Disp, 16'd5);
        cyc(0, 0, 0);
        chkw("lap.released", Disp, q_m);
        chkb("lap.rel_running", Running, 1'b1);
        cyc(0, 1, 0);
        hv = q_m;
        repeat (5) cyc(0, 0, 0);
        chkw("lap2.frozen", Disp, hv);
        chkb("lap2.counting", q_m != hv, 1'b1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chkb("lap2.paused", Running, 1'b0);
        chkw("lap2.live", Disp, q_m);
        qp = q_m;
        bad = 1'b0;
        repeat (8) begin
            cyc(0, 0, 0);
            if (En !== 1'b0) bad = 1'b1;
        end
        chkb("lap2.no_en", bad, 1'b0);
        chkw("lap2.q_still", q_m, qp);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chkw("lap.cleared", Disp, 16'h0000);

        // full scale
        @(posedge Clk);
        #1 load_val = 16'hFFFE; load_en = 1'b1;
        @(posedge Clk);
        #1 load_en = 1'b0;
        @(negedge Clk);
        chkw("fs.preload", Q, 16'hFFFE);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 0);
        chkb("fs.en1", En, 1'b1);
        chkw("fs.disp_fffe", Disp, 16'hFFFE);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 0);
        chkb("fs.en_blocked", En, 1'b0);
        chkb("fs.run_before", Running, 1'b1);
        chkw("fs.disp_ffff", Disp, 16'hFFFF);
        cyc(0, 0, 0);
        chkb("fs.ovf", Ovf, 1'b1);
        chkb("fs.halt", Running, 1'b0);
        cyc(1, 0, 0);
        bad = 1'b0;
        repeat (6) begin
            cyc(0, 0, 0);
            if (En !== 1'b0 || Running !== 1'b0) bad = 1'b1;
        end
        chkb("fs.ss_ignored", bad, 1'b0);
        chkw("fs.q_hold", Q, 16'hFFFF);
        chkb("fs.ovf_sticky", Ovf, 1'b1);
        cyc(0, 0, 1);
        chkb("fs.clr_cmd", Clr, 1'b0);
        cyc(0, 0, 0);
        chkb("fs.clr_pulse", Clr, 1'b1);
        chkb("fs.ovf_clr", Ovf, 1'b0);
        cyc(0, 0, 0);
        chkb("fs.clr_end", Clr, 1'b0);
        chkw("fs.q0", Disp, 16'h0000);

        // all three buttons on a tick cycle
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 1, 1);
        chkb("sim.en_supp", En, 1'b0);
        chkb("sim.clr_cmd", Clr, 1'b0);
        cyc(0, 0, 0);
        chkb("sim.clr", Clr, 1'b1);
        chkb("sim.idle", Running, 1'b0);
        chkw("sim.q_stay", Q, 16'h0000);
        cyc(0, 0, 0);
        chkb("sim.clr_end", Clr, 1'b0);
        chkb("sim.idle2", Running, 1'b0);

        // asynchronous reset mid-run
        cyc(1, 0, 0);
        repeat (10) cyc(0, 0, 0);
        chkw("ar.q2", Disp, 16'd2);
        chkb("ar.run", Running, 1'b1);
        @(posedge Clk);
        #3 Resetn = 1'b0;
        #1;
        chkb("ar.clr", Clr, 1'b1);
        chkb("ar.run0", Running, 1'b0);
        chkb("ar.en0", En, 1'b0);
        #9 Resetn = 1'b1;
        @(negedge Clk);
        chkb("ar.clr_hold", Clr, 1'b1);
        chkw("ar.q0", Q, 16'h0000);
        cyc(0, 0, 0);
        chkb("ar.clr_drop", Clr, 1'b0);
        chkb("ar.idle", Running, 1'b0);
        chkw("ar.disp0", Disp, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
